// File: rtl/image_load_ctrl.sv
// Image memory sequencer: loads a 784-pixel stream into the image memory, then serves range-checked reads.
// Optional build macro IMG_NORM_EN scales each pixel left by NORM_SHIFT before it is written.
module image_load_ctrl #(
   parameter int NUM_PIXELS = 784,
   parameter int ADDR_W     = 16,
   parameter int NORM_SHIFT = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              pix_valid,
   input  logic [7:0]        pix_data,
   output logic              pix_ready,
   output logic [ADDR_W-1:0] mem_write_addr,
   output logic [31:0]       mem_write_data,
   output logic              mem_write_enable,
   output logic [ADDR_W-1:0] mem_read_addr,
   input  logic [31:0]       mem_read_data,
   input  logic              rd_req,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic              rd_valid,
   output logic [31:0]       rd_data,
   output logic              rd_err,
   output logic              image_ready,
   input  logic              img_release,
   output logic [ADDR_W-1:0] pix_count
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      READY = 2'd2
   } state_t;

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_PIXELS - 1);
   localparam logic [ADDR_W-1:0] PIX_LIMIT = ADDR_W'(NUM_PIXELS);

   state_t      state;
   logic        beat;
   logic        rd_ok;
   logic [31:0] pix_word;

   // Pixel to memory word conversion; values stay non-negative either way
`ifdef IMG_NORM_EN
   assign pix_word = {24'b0, pix_data} << NORM_SHIFT;
`else
   logic unused_norm_shift;
   assign unused_norm_shift = (NORM_SHIFT != 0);
   assign pix_word = {24'b0, pix_data};
`endif

   assign pix_ready        = (state == LOAD);
   assign beat             = pix_valid & pix_ready;
   assign mem_write_enable = beat;
   assign mem_write_addr   = beat ? pix_count : '0;
   assign mem_write_data   = beat ? pix_word : '0;
   assign mem_read_addr    = rd_addr;
   assign rd_ok            = (state == READY) && (rd_addr < PIX_LIMIT);

   // Load sequencing: the final beat moves straight to READY so no address past the image is written
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         pix_count   <= '0;
         image_ready <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  state     <= LOAD;
                  pix_count <= '0;
               end
            end
            LOAD: begin
               if (beat) begin
                  pix_count <= pix_count + ADDR_W'(1);
                  if (pix_count == LAST_ADDR) begin
                     state       <= READY;
                     image_ready <= 1'b1;
                  end
               end
            end
            READY: begin
               if (start) begin
                  state       <= LOAD;
                  pix_count   <= '0;
                  image_ready <= 1'b0;
               end else if (img_release) begin
                  state       <= IDLE;
                  image_ready <= 1'b0;
               end
            end
            default: begin
               state       <= IDLE;
               pix_count   <= '0;
               image_ready <= 1'b0;
            end
         endcase
      end
   end

   // Read port: the response reflects the state seen in the request cycle; rd_data holds between requests
   always_ff @(posedge clk) begin
      if (reset) begin
         rd_valid <= 1'b0;
         rd_err   <= 1'b0;
         rd_data  <= '0;
      end else begin
         rd_valid <= rd_req;
         rd_err   <= rd_req & ~rd_ok;
         if (rd_req) begin
            rd_data <= rd_ok ? mem_read_data : '0;
         end
      end
   end

endmodule
